// File: rtl/tdm_serializer.sv
// TDM frame transmitter: latches five 16-bit channel words and sends one sync
// period followed by 80 MSB-first data bits on a divided-down bit clock.
module tdm_serializer #(
    parameter int SLOT_BITS = 16,
    parameter int HALF_DIV  = 2,
    parameter int GAP_BITS  = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic [SLOT_BITS-1:0] ch0,
    input  logic [SLOT_BITS-1:0] ch1,
    input  logic [SLOT_BITS-1:0] ch2,
    input  logic [SLOT_BITS-1:0] ch3,
    input  logic [SLOT_BITS-1:0] ch4,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 tdm_clk,
    output logic                 tdm_sync,
    output logic                 tdm_data
);
    localparam int FRAME_BITS = 5 * SLOT_BITS;
    localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [6:0] LAST_BIT = 7'(FRAME_BITS - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_BITS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_SYNC  = 3'd2,
        S_DATA  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic                    tclk_q, tclk_d;
    logic                    sync_q, sync_d;
    logic                    data_q, data_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [6:0]              bit_q, bit_d;
    logic [7:0]              gap_q, gap_d;
    logic                    div_wrap_s;
    logic                    fall_evt_s;
    logic                    xfer_s;

    // Bit-clock divider and the falling-edge strobe that paces all link updates
    always_comb begin
        div_wrap_s = (div_q == DIV_LAST);
        div_d      = div_wrap_s ? '0 : div_q + 1'b1;
        tclk_d     = div_wrap_s ? ~tclk_q : tclk_q;
        fall_evt_s = div_wrap_s & tclk_q;
        xfer_s     = frame_valid & ready_q;
    end

    // Frame sequencing: next state, link line values and shift register
    always_comb begin
        state_d = state_q;
        sync_d  = sync_q;
        data_d  = data_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                sync_d = 1'b0;
                data_d = 1'b0;
                if (xfer_s) begin
                    shift_d = {ch0, ch1, ch2, ch3, ch4};
                    state_d = S_ARMED;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARMED: begin
                if (fall_evt_s) begin
                    sync_d  = 1'b1;
                    data_d  = 1'b0;
                    state_d = S_SYNC;
                end else begin
                    state_d = S_ARMED;
                end
            end
            S_SYNC: begin
                if (fall_evt_s) begin
                    sync_d  = 1'b0;
                    data_d  = shift_q[FRAME_BITS-1];
                    shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                    bit_d   = 7'd0;
                    state_d = S_DATA;
                end else begin
                    state_d = S_SYNC;
                end
            end
            S_DATA: begin
                if (fall_evt_s) begin
                    if (bit_q != LAST_BIT) begin
                        data_d  = shift_q[FRAME_BITS-1];
                        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                        bit_d   = bit_q + 7'd1;
                    end else begin
                        data_d = 1'b0;
                        if (GAP_BITS == 0) begin
                            state_d = S_DONE;
                        end else begin
                            gap_d   = 8'd1;
                            state_d = S_GAP;
                        end
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_GAP: begin
                if (fall_evt_s) begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end else begin
                    state_d = S_GAP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers; a reset drops any frame in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            tclk_q  <= 1'b0;
            sync_q  <= 1'b0;
            data_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            shift_q <= '0;
            bit_q   <= 7'd0;
            gap_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tclk_q  <= tclk_d;
            sync_q  <= sync_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
        end
    end

    assign frame_ready = ready_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign tdm_clk     = tclk_q;
    assign tdm_sync    = sync_q;
    assign tdm_data    = data_q;

endmodule

// File: tb/tb_tdm_serializer.sv
// Scoreboard bench: three serializer configurations, each watched by a TDM
// receiver model that rebuilds channel words from the link wires.
module tb_tdm_serializer;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid_w [3];
    logic [15:0] ch_w    [3][5];
    logic        ready_w [3];
    logic        busy_w  [3];
    logic        done_w  [3];
    logic        tclk_w  [3];
    logic        tsync_w [3];
    logic        tdata_w [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rx_bits [3];
    int sent_n  [3];
    int done_n  [3];
    logic [79:0] exp_q0[$];
    logic [79:0] exp_q1[$];
    logic [79:0] exp_q2[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            tdm_serializer #(
                .SLOT_BITS(16),
                .HALF_DIV((g == 2) ? 1 : 2),
                .GAP_BITS((g == 0) ? 1 : ((g == 1) ? 0 : 3))
            ) u_dut (
                .clock      (clock),
                .reset_n    (reset_n),
                .frame_valid(valid_w[g]),
                .frame_ready(ready_w[g]),
                .ch0        (ch_w[g][0]),
                .ch1        (ch_w[g][1]),
                .ch2        (ch_w[g][2]),
                .ch3        (ch_w[g][3]),
                .ch4        (ch_w[g][4]),
                .busy       (busy_w[g]),
                .frame_done (done_w[g]),
                .tdm_clk    (tclk_w[g]),
                .tdm_sync   (tsync_w[g]),
                .tdm_data   (tdata_w[g])
            );
        end
    endgenerate

    function automatic int hd(input int k);
        return (k == 2) ? 1 : 2;
    endfunction

    function automatic int gb(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic push_exp(input int k, input logic [79:0] f);
        case (k)
            0: exp_q0.push_back(f);
            1: exp_q1.push_back(f);
            default: exp_q2.push_back(f);
        endcase
        sent_n[k]++;
    endtask

    task automatic pop_exp(input int k, output logic [79:0] f, output bit ok);
        ok = 1'b0;
        f  = '0;
        case (k)
            0: if (exp_q0.size() > 0) begin f = exp_q0.pop_front(); ok = 1'b1; end
            1: if (exp_q1.size() > 0) begin f = exp_q1.pop_front(); ok = 1'b1; end
            default: if (exp_q2.size() > 0) begin f = exp_q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    function automatic logic [79:0] rnd_frame();
        return {$urandom(), $urandom(), 16'($urandom())};
    endfunction

    // Receiver model plus frame_done timing and protocol checks for instance k
    task automatic monitor(input int k);
        logic        pclk = 1'b0, sprev = 1'b0, dprev = 1'b0, coll = 1'b0, done_exp = 1'b0;
        logic [79:0] sh = '0, e;
        bit          ok;
        int          last_rise = -1, sync_rise = 0, sync_len = 0, frame_t0 = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                pclk = 1'b0; sprev = 1'b0; dprev = 1'b0; coll = 1'b0; done_exp = 1'b0;
                last_rise = -1; sync_len = 0; rx_bits[k] = 0;
            end else begin
                if (ready_w[k] && busy_w[k])
                    chk($sformatf("ready_while_busy[%0d]", k), 80'd1, 80'd0);
                if (tsync_w[k]) begin
                    if (!sprev) begin sync_rise = cyc; sync_len = 0; end
                    sync_len++;
                end else if (sprev) begin
                    chk($sformatf("sync_len[%0d]", k), 80'(sync_len), 80'(2 * hd(k)));
                end
                sprev = tsync_w[k];
                if (tclk_w[k] && !pclk) begin
                    if (last_rise >= 0)
                        chk($sformatf("tclk_period[%0d]", k), 80'(cyc - last_rise), 80'(2 * hd(k)));
                    last_rise = cyc;
                    if (coll) begin
                        if (tsync_w[k])
                            chk($sformatf("sync_in_data[%0d]", k), 80'd1, 80'd0);
                        sh = {sh[78:0], tdata_w[k]};
                        rx_bits[k]++;
                        if (rx_bits[k] == 80) begin
                            coll = 1'b0;
                            rx_bits[k] = 0;
                            pop_exp(k, e, ok);
                            chk($sformatf("frame_expected[%0d]", k), 80'(ok), 80'd1);
                            if (ok)
                                for (int c = 0; c < 5; c++)
                                    chk($sformatf("word[%0d] ch%0d", k, c),
                                        80'(sh[79-16*c -: 16]), 80'(e[79-16*c -: 16]));
                            done_exp = 1'b1;
                        end
                    end else if (tsync_w[k]) begin
                        coll = 1'b1;
                        rx_bits[k] = 0;
                        frame_t0 = sync_rise;
                    end
                end
                pclk = tclk_w[k];
                if (done_w[k]) begin
                    if (dprev) begin
                        chk($sformatf("done_width[%0d]", k), 80'd2, 80'd1);
                    end else begin
                        chk($sformatf("done_after_frame[%0d]", k), 80'(done_exp), 80'd1);
                        chk($sformatf("done_timing[%0d]", k), 80'(cyc - frame_t0),
                            80'((81 + gb(k)) * 2 * hd(k)));
                        done_exp = 1'b0;
                        done_n[k]++;
                    end
                end
                dprev = done_w[k];
            end
        end
    endtask

    // Present a frame on instance k and wait (bounded) for the handshake
    task automatic send(input int k, input logic [79:0] f, input bit keep_valid);
        int  t = 0;
        bit  rdy, ok = 1'b0;
        for (int c = 0; c < 5; c++) ch_w[k][c] = f[79-16*c -: 16];
        valid_w[k] = 1'b1;
        while (t < 3000 && !ok) begin
            rdy = ready_w[k];
            @(negedge clock);
            t++;
            if (rdy) ok = 1'b1;
        end
        chk($sformatf("handshake_timeout[%0d]", k), 80'(ok), 80'd1);
        if (ok) push_exp(k, f);
        for (int c = 0; c < 5; c++) ch_w[k][c] = 16'($urandom());
        if (!keep_valid) valid_w[k] = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (t < 6000 && ((exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0 ||
                            busy_w[0] || busy_w[1] || busy_w[2])) begin
            @(negedge clock);
            t++;
        end
        chk("drain_timeout", 80'(t >= 6000), 80'd0);
        repeat (3) @(negedge clock);
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s tclk[%0d]", tag, k), 80'(tclk_w[k]), 80'd0);
            chk($sformatf("%s sync[%0d]", tag, k), 80'(tsync_w[k]), 80'd0);
            chk($sformatf("%s data[%0d]", tag, k), 80'(tdata_w[k]), 80'd0);
            chk($sformatf("%s busy[%0d]", tag, k), 80'(busy_w[k]), 80'd0);
            chk($sformatf("%s done[%0d]", tag, k), 80'(done_w[k]), 80'd0);
            chk($sformatf("%s ready[%0d]", tag, k), 80'(ready_w[k]), 80'd0);
        end
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs(tag);
        @(negedge clock);
        #2 reset_n = 1'b1;
        #1 for (int k = 0; k < 3; k++)
            chk($sformatf("%s ready_before_clk[%0d]", tag, k), 80'(ready_w[k]), 80'd0);
        @(negedge clock);
        for (int k = 0; k < 3; k++)
            chk($sformatf("%s ready_first_clk[%0d]", tag, k), 80'(ready_w[k]), 80'd1);
    endtask

    initial begin
        logic [79:0] f;
        int t;
        for (int k = 0; k < 3; k++) begin
            valid_w[k] = 1'b0;
            rx_bits[k] = 0;
            sent_n[k] = 0;
            done_n[k] = 0;
            for (int c = 0; c < 5; c++) ch_w[k][c] = 16'h0000;
        end
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
        #22 reset_n = 1'b1;
        repeat (7) @(negedge clock);
        reset_pulse("reset");

        fork
            begin
                send(0, {16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF, 16'h1234}, 1'b0);
                send(0, rnd_frame(), 1'b0);
                for (int i = 0; i < 20; i++) begin
                    valid_w[0] = i[0];
                    for (int c = 0; c < 5; c++) ch_w[0][c] = 16'($urandom());
                    @(negedge clock);
                    chk("ignored_valid ready[0]", 80'(ready_w[0]), 80'd0);
                end
                valid_w[0] = 1'b0;
                send(0, rnd_frame(), 1'b0);
            end
            begin
                send(1, rnd_frame(), 1'b1);
                send(1, rnd_frame(), 1'b0);
                send(1, rnd_frame(), 1'b0);
            end
            begin
                send(2, {16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF, 16'h1234}, 1'b0);
                send(2, rnd_frame(), 1'b0);
            end
        join
        drain();

        send(0, rnd_frame(), 1'b0);
        t = 0;
        while (t < 2000 && rx_bits[0] < 37) begin
            @(negedge clock);
            t++;
        end
        chk("midframe_wait_timeout", 80'(t >= 2000), 80'd0);
        exp_q0.delete();
        sent_n[0]--;
        reset_pulse("midframe_reset");
        send(0, {5{16'h5A5A}}, 1'b0);
        send(1, rnd_frame(), 1'b0);
        drain();

        for (int k = 0; k < 3; k++)
            chk($sformatf("done_count[%0d]", k), 80'(done_n[k]), 80'(sent_n[k]));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/tdm_serializer.md
Name: tdm_serializer

Overview:
- TDM frame transmitter. It is the transmit-side counterpart of the team's TDM deserializer and drives the same 3-wire link: tdm_clk, tdm_sync and tdm_data.
- It accepts five channel words per frame through a valid/ready handshake. It sends one sync period, then 80 data bits: 5 channels × 16 bits, ch0 first, MSB first.
- It generates tdm_clk from the system clock and runs entirely in the system clock domain.

Parameters:
- SLOT_BITS, 16, bits per channel slot. Fixed at 16 by the link format; other values are unsupported.
- HALF_DIV, 2, system clock cycles per tdm_clk half-period. Must be ≥1.
- GAP_BITS, 1, minimum idle tdm_clk periods (sync low) after the last data bit before the next sync. Range 0..255.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- frame_valid  input  1  frame words are presented.
- frame_ready  output  1  serializer can accept a frame.
- ch0..ch4  input  16 each  channel words, sampled on handshake.
- busy  output  1  a frame is latched or in transmission.
- frame_done  output  1  one-clock pulse when the frame (including gap) ends.
- tdm_clk  output  1  link bit clock; the receiver samples on its rising edge.
- tdm_sync  output  1  frame-start marker.
- tdm_data  output  1  serial data.

Behaviour:
- Reset (reset_n=0, async):
  - tdm_clk=0, tdm_sync=0, tdm_data=0, frame_ready=0, busy=0, frame_done=0.
  - Divider count=0, state=IDLE.
  - frame_ready rises on the first clock after reset release.
- tdm_clk generation:
  - Free-running after reset. The divider counts 0..HALF_DIV-1; tdm_clk toggles on the clock where count==HALF_DIV-1.
  - fall_evt is the clock where tdm_clk toggles 1→0.
  - All tdm_sync/tdm_data updates are registered on fall_evt only, so they are stable for a full half-period around each rising edge.
- Handshake:
  - frame_ready=1 only in IDLE. Transfer occurs when frame_valid & frame_ready on a clock edge.
  - On transfer: latch {ch0..ch4} into an 80-bit shift register (ch0[15] at MSB), go to ARMED, and drop frame_ready on the next cycle.
  - frame_valid outside IDLE is ignored. Input changes after transfer have no effect on the frame in flight.
- State machine (all transitions except IDLE→ARMED occur on fall_evt):
  - IDLE: tdm_sync=0, tdm_data=0. Transfer → ARMED.
  - ARMED: on fall_evt drive tdm_sync=1, tdm_data=0 → SYNC.
  - SYNC: on fall_evt drive tdm_sync=0, tdm_data=shift[79], shift left by 1, bit_cnt=0 → DATA.
  - DATA:
    - On fall_evt, if bit_cnt<79: drive the next MSB and increment bit_cnt.
    - If bit_cnt==79: tdm_data=0. If GAP_BITS==0, go to DONE; else gap_cnt=1 → GAP.
  - GAP: on fall_evt, if gap_cnt==GAP_BITS → DONE, else increment gap_cnt.
  - DONE: frame_done=1 for exactly one clock, then IDLE with frame_ready=1 on the following clock.
- busy=1 in ARMED, SYNC, DATA, GAP and DONE.
- Frame length on the wire: 1 sync period + 80 bit periods + GAP_BITS idle periods. Each period is 2×HALF_DIV clocks.
- Receiver contract: the receiver samples sync=1 at one rising edge; its next 80 rising edges see ch0[15]..ch0[0], ch1[15]..ch1[0], … ch4[0].
- tdm_sync is high for exactly one tdm_clk period per frame and is never high during data bits.
- With GAP_BITS=0 and frame_valid held high, the next sync is not driven earlier than the fall_evt after IDLE re-entry. The link remains receiver-legal because the receiver accepts sync directly after bit 79.
- Reset mid-frame:
  - All outputs return to their reset values immediately.
  - The latched frame is discarded, no frame_done is issued, and the partial frame is not resumed.
  - The receiver recovers on the next sync.

Test Plan:
1. Reset: assert reset_n=0 mid-toggle → tdm_clk/tdm_sync/tdm_data/busy/frame_done=0 immediately. After release, frame_ready=1 on the first clock, and tdm_clk period is 4 clocks with HALF_DIV=2.
2. Single frame: ch0=16'hA5C3, ch1=16'h0001, ch2=16'h8000, ch3=16'hFFFF, ch4=16'h1234, one-cycle valid → sync high for exactly 4 clocks. A reference TDM receiver model, sampling on rising tdm_clk, recovers all five words exactly. frame_done pulses once, (1+80+1)×4 clocks after the sync rise.
3. Back-to-back: GAP_BITS=0, frame_valid held high with two different word sets → both frames are received correctly, no sync appears during data, and exactly two frame_done pulses occur.
4. Ignored valid: change ch0..ch4 and pulse frame_valid while busy → transmitted words equal the first latched set, and frame_ready stays 0 until after frame_done.
5. Reset mid-frame: deassert reset_n after 37 data bits, release, send 16'h5A5A×5 → the receiver model outputs 16'h5A5A on all channels, and no frame_done occurs for the aborted frame.
6. HALF_DIV=1, GAP_BITS=3: send a frame → tdm_clk period is 2 clocks, 3 idle low periods follow bit 79, and the data matches.
